// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Runs one operation at a time: accept in IDLE, sample the ALU in EXEC, hold the response in RESP.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [7:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [3:0]         alu_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic               busy,
    output logic [15:0]        op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_last_grant;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_id;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_err;
    logic [15:0]        r_op_count;

    logic               w_accept;
    logic               w_grant_id;
    logic [1:0]         w_req_ready;
    logic               w_legal;
    logic               w_rsp_fire;

    always_comb begin
        case (r_op)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: w_legal = 1'b1;
            default:                             w_legal = 1'b0;
        endcase
    end

    // With both requesters valid the one not granted last wins; a lone requester always wins.
    assign w_grant_id = (&req_valid) ? ~r_last_grant : req_valid[1];
    assign w_rsp_fire = (r_state == RESP) && rsp_ready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_req_ready  = 2'b00;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_accept     = 1'b1;
                    w_req_ready  = w_grant_id ? 2'b10 : 2'b01;
                    w_state_next = EXEC;
                end
            end
            EXEC:    w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_err        <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_last_grant <= w_grant_id;
                r_id         <= w_grant_id;
                r_op         <= w_grant_id ? req_op[7:4]         : req_op[3:0];
                r_a          <= w_grant_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                r_b          <= w_grant_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            end
            // Illegal codes never expose whatever the ALU happens to produce.
            if (r_state == EXEC) begin
                r_result <= w_legal ? alu_result : '0;
                r_zero   <= w_legal ? alu_zero   : 1'b1;
                r_err    <= ~w_legal;
            end
            if (w_rsp_fire) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign req_ready  = w_req_ready;
    assign alu_op     = r_op;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;
    assign busy       = (r_state != IDLE);
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level reference model checked every
// falling edge, plus literal expectations for the key scenarios.
module tb_alu_arbiter;

    localparam int W = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [7:0]       req_op = '0;
    logic [2*W-1:0]   req_a = '0;
    logic [2*W-1:0]   req_b = '0;
    logic [3:0]       alu_op;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [W-1:0]     alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_id;
    logic [W-1:0]     rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic             busy;
    logic [15:0]      op_count;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Shared ALU; undefined codes return nonzero garbage so the block must mask it.
    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return b;
            4'd12:   return ~(a | b);
            default: return (a ^ b) | 64'h1;
        endcase
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) ||
               (op == 4'd6) || (op == 4'd7) || (op == 4'd12);
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_op, alu_a, alu_b);
        alu_zero   = (alu_result == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, response visible one cycle after acceptance.
    bit          m_pending = 1'b0;
    bit          m_visible = 1'b0;
    bit          m_last = 1'b1;
    logic [3:0]  m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    bit          m_id = 1'b0, m_zero = 1'b0, m_err = 1'b0;
    logic [15:0] m_count = '0;

    function automatic bit winner(input logic [1:0] v, input bit last);
        if (v == 2'b11) return !last;
        return v[1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending = 1'b0; m_visible = 1'b0; m_last = 1'b1;
            m_op = '0; m_a = '0; m_b = '0; m_res = '0;
            m_id = 1'b0; m_zero = 1'b0; m_err = 1'b0; m_count = '0;
        end else if (!m_pending) begin
            if (req_valid != 2'b00) begin
                m_id      = winner(req_valid, m_last);
                m_last    = m_id;
                m_op      = req_op[4*m_id +: 4];
                m_a       = req_a[W*m_id +: W];
                m_b       = req_b[W*m_id +: W];
                m_err     = !is_legal(m_op);
                m_res     = m_err ? '0 : alu_fn(m_op, m_a, m_b);
                m_zero    = (m_res == '0);
                m_pending = 1'b1;
                m_visible = 1'b0;
            end
        end else if (!m_visible) begin
            m_visible = 1'b1;
        end else if (rsp_ready) begin
            m_pending = 1'b0;
            m_visible = 1'b0;
            m_count   = m_count + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [1:0] e_ready;
            e_ready = 2'b00;
            if (!m_pending && req_valid != 2'b00)
                e_ready = winner(req_valid, m_last) ? 2'b10 : 2'b01;
            check("cmp req_ready", req_ready, e_ready);
            check("cmp busy", busy, m_pending);
            check("cmp rsp_valid", rsp_valid, m_visible);
            check("cmp alu_op", alu_op, m_op);
            check("cmp alu_a", alu_a, m_a);
            check("cmp alu_b", alu_b, m_b);
            check("cmp op_count", op_count, m_count);
            if (m_visible || !rst_n) begin
                check("cmp rsp_id", rsp_id, m_id);
                check("cmp rsp_result", rsp_result, m_res);
                check("cmp rsp_zero", rsp_zero, m_zero);
                check("cmp rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[4*i +: 4] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check(name, rsp_valid, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants[3];
        int ng;
        int n;

        step();
        step();
        cmp_en = 1'b1;
        check("reset op_count", op_count, 16'h0);
        check("reset alu_op", alu_op, 4'h0);
        check("reset busy", busy, 1'b0);
        rst_n = 1'b1;

        // Single requester ADD: 5 + 7.
        set_req(0, 4'd2, 64'd5, 64'd7);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1 check("t1 req_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("t1 exec rsp_valid", rsp_valid, 1'b0);
        check("t1 exec busy", busy, 1'b1);
        check("t1 alu_op", alu_op, 4'd2);
        check("t1 alu_a", alu_a, 64'd5);
        step();
        check("t1 rsp_valid", rsp_valid, 1'b1);
        check("t1 rsp_id", rsp_id, 1'b0);
        check("t1 rsp_result", rsp_result, 64'd12);
        check("t1 rsp_zero", rsp_zero, 1'b0);
        check("t1 rsp_err", rsp_err, 1'b0);
        step();
        check("t1 op_count", op_count, 16'd1);
        check("t1 idle", busy, 1'b0);

        // Both requesters continuously valid: grants alternate from requester 0.
        do_reset();
        set_req(0, 4'd6, 64'd9, 64'd9);
        set_req(1, 4'd0, 64'hF0, 64'h0F);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        ng = 0;
        n = 0;
        while (ng < 3 && n < 15) begin
            #1;
            if (req_ready != 2'b00) begin
                grants[ng] = req_ready[1] ? 1 : 0;
                ng++;
            end
            if (rsp_valid) begin
                check("t2 rsp_result", rsp_result, 64'd0);
                check("t2 rsp_zero", rsp_zero, 1'b1);
                check("t2 rsp_err", rsp_err, 1'b0);
            end
            step();
            n++;
        end
        req_valid = 2'b00;
        check("t2 grant count", ng, 3);
        check("t2 grant0", grants[0], 0);
        check("t2 grant1", grants[1], 1);
        check("t2 grant2", grants[2], 0);
        wait_idle("t2 drain");

        // Illegal code from requester 1 must mask the ALU output.
        set_req(1, 4'd3, 64'd5, 64'd5);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        wait_rsp("t3 rsp_valid");
        check("t3 rsp_id", rsp_id, 1'b1);
        check("t3 rsp_err", rsp_err, 1'b1);
        check("t3 rsp_result", rsp_result, 64'd0);
        check("t3 rsp_zero", rsp_zero, 1'b1);
        wait_idle("t3 drain");

        // Back-pressure: response held five cycles while both requesters wait.
        set_req(0, 4'd1, 64'd3, 64'd4);
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #1 check("t4 req_ready grant", req_ready, 2'b01);
        step();
        wait_rsp("t4 rsp_valid");
        for (int i = 0; i < 5; i++) begin
            check("t4 hold rsp_valid", rsp_valid, 1'b1);
            check("t4 hold rsp_id", rsp_id, 1'b0);
            check("t4 hold rsp_result", rsp_result, 64'd7);
            check("t4 hold req_ready", req_ready, 2'b00);
            check("t4 hold busy", busy, 1'b1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("t4 release idle", busy, 1'b0);
        #1 check("t4 next grant", req_ready, 2'b10);
        req_valid = 2'b00;
        step();

        // Reset pulsed during EXEC discards the operation.
        set_req(0, 4'd2, 64'd1, 64'd1);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        check("t5 in exec", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t5 async busy", busy, 1'b0);
        check("t5 async rsp_valid", rsp_valid, 1'b0);
        check("t5 async op_count", op_count, 16'd0);
        check("t5 async alu_op", alu_op, 4'd0);
        check("t5 async alu_a", alu_a, 64'd0);
        check("t5 async rsp_result", rsp_result, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5 no rsp", rsp_valid, 1'b0);
            check("t5 op_count", op_count, 16'd0);
            step();
        end

        // Counter wrap from 0xFFFF.
        force dut.r_op_count = 16'hFFFF;
        m_count = 16'hFFFF;
        #1 release dut.r_op_count;
        check("t6 preload", op_count, 16'hFFFF);
        set_req(0, 4'd2, 64'd1, 64'd2);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        step();
        req_valid = 2'b00;
        wait_rsp("t6 rsp_valid");
        check("t6 rsp_result", rsp_result, 64'd3);
        check("t6 before wrap", op_count, 16'hFFFF);
        step();
        check("t6 wrap", op_count, 16'h0000);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
